wfg_stim_patgen: RTL

AXI-Stream stimulus source that feeds the pattern driver stage (wfg_drive_pat), which consumes one word per sync event.
- Generates a repeating frame of digital pattern words in one of four modes: counter, walking-one, LFSR, constant.
- Asserts tlast on the final word of each frame.
- Configuration arrives as register outputs from its own wishbone register block, instantiated in the stim top.

---
 rtl/wfg_stim_patgen.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/wfg_stim_patgen.sv
// Purpose: AXI-Stream pattern source that emits repeating frames of counter, walking-one, LFSR or constant words.
// Latency: first tvalid two cycles after enable is sampled; then one word per clock under continuous ready.
// Backpressure: while tvalid is high and tready is low, tdata and tlast hold and tvalid stays high.
module wfg_stim_patgen #(
    parameter int                         AXIS_DATA_WIDTH = 32,
    parameter logic [AXIS_DATA_WIDTH-1:0] LFSR_TAPS       = AXIS_DATA_WIDTH'(32'hB4BCD35C)
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       ctrl_en_q_i,
    input  logic [1:0]                 cfg_mode_q_i,
    input  logic [AXIS_DATA_WIDTH-1:0] cfg_start_q_i,
    input  logic [15:0]                cfg_inc_q_i,
    input  logic [15:0]                cfg_len_q_i,
    input  logic                       wfg_axis_tready_i,
    output logic                       wfg_axis_tvalid_o,
    output logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_o,
    output logic                       wfg_axis_tlast_o,
    output logic                       busy_o,
    output logic [15:0]                frame_cnt_o
);

    localparam int W = AXIS_DATA_WIDTH;

    // Pattern mode encodings as seen on cfg_mode_q_i.
    localparam logic [1:0] MODE_CNT   = 2'd0;
    localparam logic [1:0] MODE_WALK  = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;
    localparam logic [1:0] MODE_CONST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t         state_q;

    // Shadow copy of the configuration, captured once per LOAD so that
    // register writes during a run cannot disturb the frame in flight.
    logic [1:0]     mode_q;
    logic [W-1:0]   start_q;
    logic [15:0]    inc_q;
    logic [15:0]    len_q;

    // Position of the currently presented word inside its frame.
    logic [15:0]    idx_q;

    // Registered stream outputs.
    logic           tvalid_q;
    logic [W-1:0]   tdata_q;
    logic           tlast_q;
    logic           busy_q;
    logic [15:0]    frame_cnt_q;

    // A beat leaves the block when both sides agree in the same cycle.
    logic           beat;
    logic           frame_end;

    assign beat      = tvalid_q & wfg_axis_tready_i;
    assign frame_end = (idx_q == len_q);

    // First word of a frame: the walking-one always starts at bit 0 and an
    // all-zero LFSR seed is forced to 1, since zero is a lock-up state.
    function automatic logic [W-1:0] init_word(input logic [1:0]   mode,
                                               input logic [W-1:0] start);
        logic [W-1:0] w;
        w = start;
        case (mode)
            MODE_WALK: w = W'(1);
            MODE_LFSR: w = (start == '0) ? W'(1) : start;
            default:   w = start;
        endcase
        return w;
    endfunction

    // Successor of the current word; all arithmetic wraps at 2^W.
    function automatic logic [W-1:0] next_word(input logic [1:0]   mode,
                                               input logic [W-1:0] d,
                                               input logic [15:0]  inc);
        logic [W-1:0] w;
        w = d;
        case (mode)
            MODE_CNT:   w = d + W'(inc);
            MODE_WALK:  w = {d[W-2:0], d[W-1]};
            MODE_LFSR:  w = (d >> 1) ^ (d[0] ? LFSR_TAPS : '0);
            MODE_CONST: w = d;
            default:    w = d;
        endcase
        return w;
    endfunction

    // Control FSM with every output registered: IDLE waits for enable, LOAD
    // snapshots the config and prepares word 0, RUN streams until disabled.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_CNT;
            start_q     <= '0;
            inc_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tvalid_q <= 1'b0;
                    tlast_q  <= 1'b0;
                    if (ctrl_en_q_i) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    // Always a single cycle; tvalid rises on the first RUN cycle.
                    mode_q  <= cfg_mode_q_i;
                    start_q <= cfg_start_q_i;
                    inc_q   <= cfg_inc_q_i;
                    len_q   <= cfg_len_q_i;
                    idx_q   <= '0;
                    tdata_q <= init_word(cfg_mode_q_i, cfg_start_q_i);
                    tlast_q <= (cfg_len_q_i == 16'd0);
                    busy_q  <= 1'b1;
                    state_q <= ST_RUN;
                end

                ST_RUN: begin
                    if (beat) begin
                        // The final beat of a frame counts even when it is
                        // also the beat that closes out a disable.
                        if (frame_end) begin
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                        end
                        if (ctrl_en_q_i) begin
                            if (frame_end) begin
                                idx_q   <= '0;
                                tdata_q <= init_word(mode_q, start_q);
                                tlast_q <= (len_q == 16'd0);
                            end else begin
                                idx_q   <= idx_q + 16'd1;
                                tdata_q <= next_word(mode_q, tdata_q, inc_q);
                                tlast_q <= ((idx_q + 16'd1) == len_q);
                            end
                        end else begin
                            // Disable honoured on a beat boundary; tdata keeps
                            // the last transferred word.
                            state_q  <= ST_IDLE;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            busy_q   <= 1'b0;
                        end
                    end else if (!tvalid_q) begin
                        // Entry cycle of RUN: nothing offered yet, so a
                        // disable here needs no handshake.
                        if (ctrl_en_q_i) begin
                            tvalid_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            tlast_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end
                    // Otherwise a stalled beat: everything holds.
                end

                default: begin
                    state_q  <= ST_IDLE;
                    tvalid_q <= 1'b0;
                    tlast_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign wfg_axis_tvalid_o = tvalid_q;
    assign wfg_axis_tdata_o  = tdata_q;
    assign wfg_axis_tlast_o  = tlast_q;
    assign busy_o            = busy_q;
    assign frame_cnt_o       = frame_cnt_q;

endmodule
